// File: rtl/ifetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch_unit: fetch PC, imem request/response handling, response FIFO and  |
// | registered decode-facing output.                  Rev 1.0 - initial       |
// +--------------------------------------------------------------------------+
module ifetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_v_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rsp_v_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            stall_i,
  input  logic            flush_v_q_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic [XLEN-1:0] instr_q_o,
  output logic [XLEN-1:0] pc0_q_o,
  output logic            instr_v_q_o,
  output logic            fetch_fault_q_o,
  output logic            fetch_misalign_q_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    c_depth   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0]   c_nop     = XLEN'(32'h0000_0013);
  localparam logic [0:0]        c_st_run  = 1'b0;
  localparam logic [0:0]        c_st_halt = 1'b1;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [0:0]       r_state;
  logic             r_started;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [XLEN-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0]  r_fifo_pc   [FIFO_DEPTH];
  logic             r_fifo_err  [FIFO_DEPTH];
  logic [XLEN-1:0]  r_instr;
  logic [XLEN-1:0]  r_pc0;
  logic             r_instr_v;
  logic             r_fault;
  logic             r_misalign;

  logic w_credit, w_req_v, w_grant, w_push, w_pop, w_drop_rsp, w_flush_ok;

  // Credits cover both in-flight requests and buffered entries, so the FIFO can never overflow.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_depth;
  assign w_req_v    = r_started & (r_state == c_st_run) & ~flush_v_q_i & w_credit;
  assign w_grant    = w_req_v & imem_gnt_i;
  assign w_drop_rsp = imem_rsp_v_i & ~flush_v_q_i & (r_drop != '0);
  assign w_push     = imem_rsp_v_i & ~flush_v_q_i & (r_drop == '0);
  assign w_pop      = ~flush_v_q_i & ~stall_i & (r_count != '0);
  assign w_flush_ok = (flush_pc_i[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_VECTOR;
      r_rsp_pc      <= RESET_VECTOR;
      r_state       <= c_st_run;
      r_started     <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rsp_v_i);
      if (flush_v_q_i) begin
        // Whatever is still in flight after this cycle belongs to the old stream.
        r_drop   <= r_outstanding - CNT_W'(imem_rsp_v_i);
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_state  <= w_flush_ok ? c_st_run : c_st_halt;
        if (w_flush_ok) begin
          r_pc     <= flush_pc_i;
          r_rsp_pc <= flush_pc_i;
        end
      end else begin
        if (w_drop_rsp) r_drop <= r_drop - CNT_W'(1);
        if (w_grant) r_pc <= r_pc + XLEN'(4);
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (imem_rsp_err_i) r_state <= c_st_halt;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data_i;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
      r_fifo_err[r_wr_ptr]  <= imem_rsp_err_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= c_nop;
      r_pc0      <= RESET_VECTOR;
      r_instr_v  <= 1'b0;
      r_fault    <= 1'b0;
      r_misalign <= 1'b0;
    end else if (flush_v_q_i) begin
      r_instr    <= c_nop;
      r_instr_v  <= 1'b0;
      r_fault    <= 1'b0;
      r_misalign <= ~w_flush_ok;
      if (!w_flush_ok) r_pc0 <= flush_pc_i;
    end else if (!stall_i) begin
      if (w_pop) begin
        r_instr   <= r_fifo_err[r_rd_ptr] ? c_nop : r_fifo_data[r_rd_ptr];
        r_pc0     <= r_fifo_pc[r_rd_ptr];
        r_instr_v <= 1'b1;
        r_fault   <= r_fifo_err[r_rd_ptr];
      end else begin
        r_instr   <= c_nop;
        r_instr_v <= 1'b0;
        r_fault   <= 1'b0;
      end
    end
  end

  assign imem_req_v_o       = w_req_v;
  assign imem_adr_o         = r_pc;
  assign instr_q_o          = r_instr;
  assign pc0_q_o            = r_pc0;
  assign instr_v_q_o        = r_instr_v;
  assign fetch_fault_q_o    = r_fault;
  assign fetch_misalign_q_o = r_misalign;

`ifndef SYNTHESIS
  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_v_i |-> (r_outstanding != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// tb_ifetch_unit: scoreboard bench for ifetch_unit with an in-order 1-cycle memory model.
module tb_ifetch_unit;

  localparam logic [31:0] c_nop   = 32'h0000_0013;
  localparam logic [31:0] c_reset = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_v_o;
  logic [31:0] imem_adr_o;
  logic        imem_gnt_i;
  logic        imem_rsp_v_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        stall_i;
  logic        flush_v_q_i;
  logic [31:0] flush_pc_i;
  logic [31:0] instr_q_o;
  logic [31:0] pc0_q_o;
  logic        instr_v_q_o;
  logic        fetch_fault_q_o;
  logic        fetch_misalign_q_o;

  always #5 clk = ~clk;

  ifetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .imem_req_v_o      (imem_req_v_o),
    .imem_adr_o        (imem_adr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rsp_v_i      (imem_rsp_v_i),
    .imem_rsp_data_i   (imem_rsp_data_i),
    .imem_rsp_err_i    (imem_rsp_err_i),
    .stall_i           (stall_i),
    .flush_v_q_i       (flush_v_q_i),
    .flush_pc_i        (flush_pc_i),
    .instr_q_o         (instr_q_o),
    .pc0_q_o           (pc0_q_o),
    .instr_v_q_o       (instr_v_q_o),
    .fetch_fault_q_o   (fetch_fault_q_o),
    .fetch_misalign_q_o(fetch_misalign_q_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // memory model and scoreboard state
  logic [31:0] pend_adr[$];
  int          pend_ep[$];
  logic [31:0] sb_pc[$];
  logic [31:0] sb_instr[$];
  logic        sb_fault[$];
  int          epoch = 0;
  int          cur_ep = 0;
  logic [31:0] cur_adr = '0;
  logic        gnt_en = 1'b1;
  logic        mem_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          cycle = 0;
  int          n_grants = 0;
  int          n_out = 0;
  int          first_grant = -1;
  int          first_valid = -1;
  logic        last_stall = 1'b0;
  logic        last_flush = 1'b0;
  logic [31:0] hold_pc = c_reset;
  logic [31:0] hold_instr = c_nop;
  logic        hold_v = 1'b0;
  logic        m_mis = 1'b0;
  logic        watch_on = 1'b0;
  logic [31:0] watch_pc = '0;
  logic [31:0] fault_pc = 32'hFFFF_FFFF;

  task automatic monitor();
    logic [31:0] e_pc, e_instr;
    logic        e_fault;
    check("misalign", 32'(fetch_misalign_q_o), 32'(m_mis));
    if (last_flush) begin
      check("flush_v", 32'(instr_v_q_o), 32'd0);
      check("flush_fault", 32'(fetch_fault_q_o), 32'd0);
      check("flush_instr", instr_q_o, c_nop);
      check("flush_pc0", pc0_q_o, hold_pc);
    end else if (last_stall) begin
      check("hold_v", 32'(instr_v_q_o), 32'(hold_v));
      check("hold_instr", instr_q_o, hold_instr);
      check("hold_pc0", pc0_q_o, hold_pc);
    end else if (instr_v_q_o) begin
      if (sb_pc.size() == 0) begin
        check("unexpected_v", 32'(instr_v_q_o), 32'd0);
      end else begin
        e_pc    = sb_pc.pop_front();
        e_instr = sb_instr.pop_front();
        e_fault = sb_fault.pop_front();
        check("out_pc0", pc0_q_o, e_pc);
        check("out_instr", instr_q_o, e_instr);
        check("out_fault", 32'(fetch_fault_q_o), 32'(e_fault));
        hold_pc = e_pc; hold_instr = e_instr; hold_v = 1'b1;
        n_out++;
        if (e_fault) fault_pc = e_pc;
        if (first_valid < 0) first_valid = cycle;
        if (watch_on) begin
          check("first_after_flush", pc0_q_o, watch_pc);
          watch_on = 1'b0;
        end
      end
    end else begin
      check("idle_instr", instr_q_o, c_nop);
      check("idle_fault", 32'(fetch_fault_q_o), 32'd0);
      check("idle_pc0", pc0_q_o, hold_pc);
      hold_v = 1'b0; hold_instr = c_nop;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    if (imem_rsp_v_i && cur_ep == epoch) begin
      sb_pc.push_back(cur_adr);
      sb_instr.push_back(imem_rsp_err_i ? c_nop : cur_adr);
      sb_fault.push_back(imem_rsp_err_i);
    end
    if (imem_req_v_o && imem_gnt_i) begin
      pend_adr.push_back(imem_adr_o);
      pend_ep.push_back(epoch);
      n_grants++;
      if (first_grant < 0) first_grant = cycle;
    end
    last_stall = stall_i;
    last_flush = flush_v_q_i;
    @(negedge clk);
    monitor();
    if (mem_en && pend_adr.size() > 0) begin
      cur_adr         = pend_adr.pop_front();
      cur_ep          = pend_ep.pop_front();
      imem_rsp_v_i    = 1'b1;
      imem_rsp_data_i = cur_adr;
      imem_rsp_err_i  = (cur_adr == err_addr);
    end else begin
      imem_rsp_v_i    = 1'b0;
      imem_rsp_data_i = '0;
      imem_rsp_err_i  = 1'b0;
    end
    imem_gnt_i = gnt_en;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush_v_q_i = 1'b1;
    flush_pc_i  = pc;
    epoch++;
    sb_pc.delete(); sb_instr.delete(); sb_fault.delete();
    hold_v = 1'b0; hold_instr = c_nop;
    m_mis = (pc[1:0] != 2'b00);
    if (m_mis) hold_pc = pc;
    watch_on = !m_mis;
    watch_pc = pc;
    step();
    flush_v_q_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset_n = 1'b0; imem_gnt_i = 1'b1; imem_rsp_v_i = 1'b0; imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0; stall_i = 1'b0; flush_v_q_i = 1'b0; flush_pc_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req_v", 32'(imem_req_v_o), 32'd0);
    check("rst_instr", instr_q_o, c_nop);
    check("rst_pc0", pc0_q_o, c_reset);
    check("rst_v", 32'(instr_v_q_o), 32'd0);
    check("rst_fault", 32'(fetch_fault_q_o), 32'd0);
    check("rst_misalign", 32'(fetch_misalign_q_o), 32'd0);
    reset_n = 1'b1;
    #1;
    check("req_after_release", 32'(imem_req_v_o), 32'd0);

    // streaming from the reset vector
    repeat (20) step();
    // grant edge counted as the first of the three edges
    check("first_valid_latency", 32'(first_valid - first_grant), 32'd2);
    check("stream_has_output", 32'(n_out > 5), 32'd1);

    // stall with the FIFO filling up
    stall_i = 1'b1;
    repeat (5) step();
    check("credit_exhausted_req", 32'(imem_req_v_o), 32'd0);
    stall_i = 1'b0;
    repeat (10) step();

    // flush with two stale requests in flight
    mem_en = 1'b0;
    repeat (5) step();
    check("two_in_flight", 32'(pend_adr.size()), 32'd2);
    do_flush(32'h100);
    mem_en = 1'b1;
    repeat (15) step();
    check("flush100_delivered", 32'(watch_on), 32'd0);

    // flush coinciding with a response, outstanding = 2
    mem_en = 1'b0;
    repeat (5) step();
    check("two_in_flight_b", 32'(pend_adr.size()), 32'd2);
    mem_en = 1'b1;
    step();
    do_flush(32'h180);
    repeat (15) step();
    check("flush180_delivered", 32'(watch_on), 32'd0);

    // access fault at 0x8 halts fetch
    err_addr = 32'h8;
    do_flush(32'h0);
    repeat (15) step();
    g = n_grants;
    repeat (8) step();
    check("fault_pc", fault_pc, 32'h8);
    check("halt_no_grants", 32'(n_grants - g), 32'd0);
    check("halt_req_v", 32'(imem_req_v_o), 32'd0);
    err_addr = 32'hFFFF_FFFF;
    do_flush(32'h200);
    repeat (15) step();
    check("flush200_delivered", 32'(watch_on), 32'd0);

    // misaligned redirect
    do_flush(32'h102);
    g = n_grants;
    repeat (8) step();
    check("misalign_no_grants", 32'(n_grants - g), 32'd0);
    check("misalign_req_v", 32'(imem_req_v_o), 32'd0);
    do_flush(32'h300);
    repeat (15) step();
    check("flush300_delivered", 32'(watch_on), 32'd0);

    // drain and confirm nothing expected was lost
    gnt_en = 1'b0;
    repeat (10) step();
    check("sb_drained", 32'(sb_pc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
